// File: rtl/button_raster.sv
// button_raster: draws one bevelled square button per request into the frame
// buffer in raster order, then pulses done_x/done_y to step the upstream
// board sequencer and raises board_done once the whole grid is drawn.
module button_raster #(
    parameter int          BEVEL       = 2,
    parameter logic [11:0] COLOR_LIGHT = 12'hFFF,
    parameter logic [11:0] COLOR_DARK  = 12'h555,
    parameter logic [11:0] COLOR_FILL  = 12'hAAA,
    parameter int          HOLD        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        draw_button,
    input  logic [6:0]  button_size,
    input  logic [10:0] button_xpos,
    input  logic [10:0] button_ypos,
    input  logic [4:0]  button_num,
    input  logic        fb_ready,
    output logic        fb_we,
    output logic [10:0] fb_x,
    output logic [10:0] fb_y,
    output logic [11:0] fb_rgb,
    output logic        done_x,
    output logic        done_y,
    output logic        board_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIXEL,
        S_DONE,
        S_SETTLE,
        S_FINISHED
    } state_t;

    localparam logic [8:0] BEV       = 9'(BEVEL);
    localparam logic [2:0] HOLD_LAST = 3'(HOLD - 1);

    // Bevel colour: light edge wins over dark edge, so undersized buttons
    // still come out with a consistent top/left highlight.
    function automatic logic [11:0] shade(input logic [6:0] x,
                                          input logic [6:0] y,
                                          input logic [6:0] s);
        logic [8:0] xe;
        logic [8:0] ye;
        xe = {2'b00, x} + BEV;
        ye = {2'b00, y} + BEV;
        if (({2'b00, x} < BEV) || ({2'b00, y} < BEV))
            shade = COLOR_LIGHT;
        else if ((xe >= {2'b00, s}) || (ye >= {2'b00, s}))
            shade = COLOR_DARK;
        else
            shade = COLOR_FILL;
    endfunction

    state_t      state, state_n;
    logic [6:0]  size_q, size_n;
    logic [10:0] xpos_q, xpos_n;
    logic [10:0] ypos_q, ypos_n;
    logic [4:0]  num_q, num_n;
    logic [6:0]  px, px_n;
    logic [6:0]  py, py_n;
    logic [4:0]  col, col_n;
    logic [4:0]  row, row_n;
    logic [2:0]  hold_cnt, hold_n;

    logic        we_n;
    logic [10:0] x_n;
    logic [10:0] y_n;
    logic [11:0] rgb_n;
    logic        done_x_n;
    logic        done_y_n;
    logic        board_done_n;
    logic        busy_n;
    logic        last_col;
    logic        last_row;

    assign last_col = (col == 5'(num_q - 5'd1));
    assign last_row = (row == 5'(num_q - 5'd1));

    // Next-state and datapath: geometry is only sampled in IDLE, so anything
    // the sequencer does to its inputs while we draw is ignored.
    always_comb begin
        state_n  = state;
        size_n   = size_q;
        xpos_n   = xpos_q;
        ypos_n   = ypos_q;
        num_n    = num_q;
        px_n     = px;
        py_n     = py;
        col_n    = col;
        row_n    = row;
        hold_n   = hold_cnt;
        case (state)
            S_IDLE: begin
                if (draw_button) begin
                    size_n  = button_size;
                    xpos_n  = button_xpos;
                    ypos_n  = button_ypos;
                    num_n   = (button_num == 5'd0) ? 5'd1 : button_num;
                    px_n    = '0;
                    py_n    = '0;
                    state_n = (button_size == 7'd0) ? S_DONE : S_PIXEL;
                end
            end
            S_PIXEL: begin
                if (fb_we && fb_ready) begin
                    if (px == 7'(size_q - 7'd1)) begin
                        px_n = '0;
                        if (py == 7'(size_q - 7'd1)) begin
                            py_n    = '0;
                            state_n = S_DONE;
                        end else begin
                            py_n = py + 7'd1;
                        end
                    end else begin
                        px_n = px + 7'd1;
                    end
                end
            end
            S_DONE: begin
                if (last_col && last_row) begin
                    state_n = S_FINISHED;
                end else begin
                    if (last_col) begin
                        col_n = '0;
                        row_n = row + 5'd1;
                    end else begin
                        col_n = col + 5'd1;
                    end
                    hold_n  = '0;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Gives the sequencer time to turn done_x into fresh geometry.
                if (hold_cnt == HOLD_LAST)
                    state_n = S_IDLE;
                else
                    hold_n = hold_cnt + 3'd1;
            end
            S_FINISHED: begin
                if (!draw_button) begin
                    col_n   = '0;
                    row_n   = '0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state so that
    // every output can be driven straight from a flop.
    always_comb begin
        we_n         = (state_n == S_PIXEL);
        x_n          = we_n ? 11'(xpos_n + {4'b0000, px_n}) : '0;
        y_n          = we_n ? 11'(ypos_n + {4'b0000, py_n}) : '0;
        rgb_n        = we_n ? shade(px_n, py_n, size_n) : '0;
        done_x_n     = (state_n == S_DONE);
        done_y_n     = (state_n == S_DONE) && (col_n == 5'(num_n - 5'd1));
        board_done_n = (state_n == S_FINISHED);
        busy_n       = (state_n == S_PIXEL) || (state_n == S_DONE) ||
                       (state_n == S_SETTLE);
    end

    // State, datapath and registered outputs; reset aborts any write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            size_q     <= '0;
            xpos_q     <= '0;
            ypos_q     <= '0;
            num_q      <= 5'd1;
            px         <= '0;
            py         <= '0;
            col        <= '0;
            row        <= '0;
            hold_cnt   <= '0;
            fb_we      <= 1'b0;
            fb_x       <= '0;
            fb_y       <= '0;
            fb_rgb     <= '0;
            done_x     <= 1'b0;
            done_y     <= 1'b0;
            board_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            size_q     <= size_n;
            xpos_q     <= xpos_n;
            ypos_q     <= ypos_n;
            num_q      <= num_n;
            px         <= px_n;
            py         <= py_n;
            col        <= col_n;
            row        <= row_n;
            hold_cnt   <= hold_n;
            fb_we      <= we_n;
            fb_x       <= x_n;
            fb_y       <= y_n;
            fb_rgb     <= rgb_n;
            done_x     <= done_x_n;
            done_y     <= done_y_n;
            board_done <= board_done_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_button_raster.sv
// tb_button_raster: directed + randomized boards checked against a pixel-list
// model built from the bevel rule and the sequencer's grid arithmetic.
module tb_button_raster;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        draw_button;
    logic [6:0]  button_size;
    logic [10:0] button_xpos;
    logic [10:0] button_ypos;
    logic [4:0]  button_num;
    logic        fb_ready;
    logic        fb_we;
    logic [10:0] fb_x;
    logic [10:0] fb_y;
    logic [11:0] fb_rgb;
    logic        done_x;
    logic        done_y;
    logic        board_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int pat_i  = 0;
    logic [3:0] pat = 4'b1001;
    logic [33:0] exp_q[$];

    button_raster #(.HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .draw_button(draw_button),
        .button_size(button_size), .button_xpos(button_xpos),
        .button_ypos(button_ypos), .button_num(button_num),
        .fb_ready(fb_ready), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
        .fb_rgb(fb_rgb), .done_x(done_x), .done_y(done_y),
        .board_done(board_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int px, input int py, input int s);
        if (px < 2 || py < 2)           return 12'hFFF;
        if (px >= s - 2 || py >= s - 2) return 12'h555;
        return 12'hAAA;
    endfunction

    // Drive inputs right after the falling edge; outputs sampled afterwards
    // therefore see the values the next rising edge will act on.
    task automatic tick(input int mode);
        @(negedge clk);
        case (mode)
            0:       fb_ready = 1'b1;
            1:       fb_ready = pat[pat_i % 4];
            default: fb_ready = ($urandom_range(0, 3) != 0);
        endcase
        pat_i++;
    endtask

    task automatic set_geom(input int b, input int n, input int size, input int x0, input int y0);
        button_size = 7'(size);
        button_xpos = 11'((x0 + (b % n) * size) % 2048);
        button_ypos = 11'((y0 + (b / n) * size) % 2048);
    endtask

    task automatic run_board(input int num, input int size, input int x0, input int y0, input int mode);
        int n, nb, bcount, writes, last_done, budget, bx, by;
        bit seen_bd, prev_stall;
        logic [33:0] prev_w;
        n = (num == 0) ? 1 : num;
        nb = n * n;
        bcount = 0; writes = 0; last_done = 0; seen_bd = 0; prev_stall = 0; prev_w = '0;
        budget = nb * (size * size * 4 + HOLD + 8) + 20;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            bx = x0 + (b % n) * size;
            by = y0 + (b / n) * size;
            for (int y = 0; y < size; y++)
                for (int x = 0; x < size; x++)
                    exp_q.push_back({11'((bx + x) % 2048), 11'((by + y) % 2048), model_rgb(x, y, size)});
        end
        button_num = 5'(num);
        set_geom(0, n, size, x0, y0);
        draw_button = 1'b1;
        for (int c = 0; c < budget && !seen_bd; c++) begin
            tick(mode);
            if (prev_stall) chk("stall_hold", {29'd0, fb_we, fb_x, fb_y, fb_rgb}, {29'd0, 1'b1, prev_w});
            if (fb_we && fb_ready) begin
                writes++;
                if (exp_q.size() == 0) chk("extra_write", 64'd1, 64'd0);
                else chk("pixel", {30'd0, fb_x, fb_y, fb_rgb}, {30'd0, exp_q.pop_front()});
            end
            prev_stall = fb_we && !fb_ready;
            prev_w     = {fb_x, fb_y, fb_rgb};
            if (fb_we && mode == 2) begin
                // junk geometry while drawing must not leak into the button
                button_size = 7'($urandom_range(0, 127));
                button_xpos = 11'($urandom_range(0, 2047));
                button_ypos = 11'($urandom_range(0, 2047));
            end
            if (done_y && !done_x) chk("done_y_alone", 64'd1, 64'd0);
            if (done_x) begin
                chk("done_y", 64'(done_y), 64'((bcount % n) == n - 1));
                chk("btn_writes", 64'(writes), 64'((bcount + 1) * size * size));
                if (mode == 0 && bcount > 0)
                    chk("btn_period", 64'(c - last_done), 64'(size * size + 2 + HOLD));
                last_done = c;
                bcount++;
                if (bcount < nb) set_geom(bcount, n, size, x0, y0);
            end
            if (board_done) begin
                seen_bd = 1;
                chk("bd_count", 64'(bcount), 64'(nb));
                chk("bd_timing", 64'(c - last_done), 64'd1);
            end
        end
        chk("bd_seen", 64'(seen_bd), 64'd1);
        chk("total_writes", 64'(writes), 64'(nb * size * size));
        repeat (3) begin
            tick(mode);
            chk("bd_hold", 64'(board_done), 64'd1);
            chk("no_write_finished", 64'(fb_we), 64'd0);
        end
        draw_button = 1'b0;
        tick(mode);
        chk("bd_clear", 64'(board_done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int writes;
        rst_n = 1'b0; draw_button = 1'b0; fb_ready = 1'b0;
        button_size = '0; button_xpos = '0; button_ypos = '0; button_num = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {25'd0, fb_we, fb_x, fb_y, fb_rgb, done_x, done_y, board_done, busy}, 64'd0);
        rst_n = 1'b1;
        repeat (10) begin
            tick(0);
            chk("idle_no_write", {62'd0, fb_we, busy}, 64'd0);
        end

        run_board(1, 6, 100, 50, 0);        // single button
        run_board(1, 6, 100, 50, 1);        // 1,0,0,1 backpressure
        run_board(3, 4, 40, 30, 2);         // 3x3 board, random stalls
        run_board(1, 0, 10, 10, 0);         // empty button
        run_board(1, 4, 2046, 10, 0);       // x wraps
        run_board(0, 3, 500, 600, 0);       // num 0 acts as 1
        run_board(2, 0, 7, 7, 0);           // empty buttons on a 2x2 board
        repeat (4)
            run_board(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                      int'($urandom_range(0, 2)));

        // reset while the 10th pixel is on the bus
        button_num = 5'd1; button_size = 7'd5; button_xpos = 11'd300; button_ypos = 11'd200;
        draw_button = 1'b1;
        writes = 0;
        for (int c = 0; c < 100 && writes < 9; c++) begin
            tick(0);
            if (fb_we && fb_ready) writes++;
        end
        chk("pre_reset_writes", 64'(writes), 64'd9);
        #2 rst_n = 1'b0;
        #1 chk("midreset_outputs", {25'd0, fb_we, fb_x, fb_y, fb_rgb, done_x, done_y, board_done, busy}, 64'd0);
        draw_button = 1'b0;
        repeat (3) begin
            tick(0);
            chk("reset_held_no_write", 64'(fb_we), 64'd0);
        end
        rst_n = 1'b1;
        run_board(2, 3, 10, 20, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_raster.md
# button_raster

Pixel-level rasterizer directly downstream of the board sequencer.
- Accepts one button request at a time: top-left position plus square size.
- Walks every pixel of that button in raster order and writes a bevelled colour into the frame buffer through a ready/valid write port.
- Returns `done_x`/`done_y` pulses that advance the sequencer's column/row counters, and flags completion of the whole board.

## Interface
Parameters:
- BEVEL, 2: bevel thickness in pixels.
- COLOR_LIGHT, 12'hFFF: top/left bevel colour (RGB444).
- COLOR_DARK, 12'h555: bottom/right bevel colour.
- COLOR_FILL, 12'hAAA: interior colour.
- HOLD, 2: settle cycles after each done pulse before a new request is sampled (1..7).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- draw_button  in  1  request level; geometry valid while high.
- button_size  in  7  button edge length in pixels.
- button_xpos  in  11  button left x.
- button_ypos  in  11  button top y.
- button_num  in  5  buttons per row and per column; 0 treated as 1.
- fb_ready  in  1  frame buffer accepts the write this cycle.
- fb_we  out  1  write valid.
- fb_x  out  11  write x address.
- fb_y  out  11  write y address.
- fb_rgb  out  12  write colour.
- done_x  out  1  one-cycle pulse, button finished.
- done_y  out  1  one-cycle pulse, finished button was last in its row.
- board_done  out  1  level, all button_num×button_num buttons drawn.
- busy  out  1  high in every state except IDLE and FINISHED.

## Operation
- FSM states: IDLE, PIXEL, DONE, SETTLE, FINISHED.
- **IDLE**
  - If draw_button=1: latch size/xpos/ypos/button_num into registers, clear px=py=0, go to PIXEL.
  - If size=0: go directly to DONE; no write is issued.
- **PIXEL**
  - fb_we=1, fb_x=xpos+px, fb_y=ypos+py. Addition is 11-bit with wrap-around, no saturation.
  - On fb_we & fb_ready: px increments.
  - At px=size-1: px returns to 0 and py increments.
  - At px=py=size-1: go to DONE.
  - Without fb_ready: fb_we, fb_x, fb_y and fb_rgb hold stable.
- **Colour rule** (first match wins):
  1. px<BEVEL or py<BEVEL → COLOR_LIGHT.
  2. px≥size-BEVEL or py≥size-BEVEL → COLOR_DARK.
  3. Otherwise → COLOR_FILL.
  - The same rule applies when size<2·BEVEL.
- **DONE** (one cycle)
  - done_x=1.
  - done_y=1 iff col=num-1.
  - If col=num-1 and row=num-1: board_done is set next cycle and the state goes to FINISHED.
  - Otherwise col increments; if col=num-1, col returns to 0 and row increments. Go to SETTLE.
- **SETTLE**: counts HOLD cycles, then IDLE. This covers upstream counter-plus-register latency, so stale geometry is never sampled.
- **FINISHED**
  - board_done=1.
  - Stays here while draw_button=1.
  - When draw_button=0: clears col/row, drops board_done and goes to IDLE.
- Changes to geometry inputs outside IDLE are ignored; only the latched values are used.
- **Reset**: asynchronous, effective at any time, including mid-write.
  - State goes to IDLE; px, py, col and row are cleared.
  - All outputs go to 0: fb_we, fb_x, fb_y, fb_rgb, done_x, done_y, board_done, busy.

## Timing
- All outputs are registered.
- Request accepted at edge k: first fb_we=1 appears in cycle k+1.
- With fb_ready held at 1, one pixel is written per cycle. A button takes size² write cycles.
- done_x is high in the cycle after the last accepted write.
- Next request is sampled at the earliest HOLD+1 cycles after done_x.
- Per button, with no backpressure: size² + 2 + HOLD cycles from acceptance to the next acceptance.
- done_x and done_y are coincident when done_y fires; neither pulse is ever longer than one cycle.
- board_done rises the cycle after the final done_x.
- rst_n deasserted mid-button: no further writes. A new request is accepted no earlier than the first clock edge after rst_n returns high.

## Test plan
- Reset values: rst_n=0 → all outputs 0, busy=0. Release rst_n, keep draw_button=0 for 10 cycles → fb_we stays 0.
- Single button: size=6, pos (100,50), num=1, fb_ready=1.
  - Exactly 36 writes, raster order from (100,50) to (105,55).
  - (101,51) is FFF; (104,52) is 555; (102,53) is AAA.
  - done_x and done_y pulse once; board_done=1.
- Backpressure: fb_ready toggles 1,0,0,1 per pixel → address and colour hold during stalls, no pixel is skipped or duplicated, 36 writes total.
- Board: num=3, size=4, fed by the upstream sequencer.
  - 9 done_x pulses; done_y on the 3rd, 6th and 9th.
  - board_done after the 9th; total writes 144.
  - board_done clears only after draw_button=0.
- Edges:
  - size=0 → DONE with no writes.
  - xpos=2046, size=4 → fb_x sequence is 2046, 2047, 0, 1.
  - num=0 → behaves as num=1.
- Mid-operation reset: rst_n=0 during the 10th pixel → outputs 0 immediately. After release, a new request starts again at px=py=0, col=row=0.
